pwm_cfg_sequencer: RTL and testbench

Bus-master controller that configures the PWM peripheral bank. It accepts per-channel configuration requests (enable, period, duty) from up to NCH requesters, such as the per-face servo controllers. Requests are arbitrated round-robin, and each granted request is serialised into a fixed, glitch-safe sequence of single-cycle register writes on the shared cs/wr/rd/adr/d_in peripheral bus. It replaces free-running, hard-coded write sequencing with a request-driven scheduler.

---
 rtl/pwm_cfg_pkg.sv | 19 +
 rtl/pwm_cfg_sequencer_if.sv | 13 +
 rtl/pwm_cfg_sequencer_rr_arbiter.sv | 35 +++
 rtl/pwm_cfg_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared constants and state encoding for the PWM configuration sequencer.
package pwm_cfg_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] REG_OFS_EN   = 32'd0;
  localparam logic [DATA_W-1:0] REG_OFS_PER  = 32'd4;
  localparam logic [DATA_W-1:0] REG_OFS_DUTY = 32'd8;
  localparam logic [DATA_W-1:0] REG_STRIDE   = 32'd12;

  typedef enum logic [2:0] {
    IDLE,
    W_DIS,
    W_PER,
    W_DUTY,
    W_EN
  } state_e;

endpackage

// File: rtl/pwm_cfg_sequencer_if.sv
// Write-only peripheral bus between the sequencer and the PWM register bank.
interface pwm_cfg_sequencer_if;

  logic [pwm_cfg_pkg::DATA_W-1:0] adr;
  logic                           cs;
  logic                           wr;
  logic                           rd;
  logic [pwm_cfg_pkg::DATA_W-1:0] d_in;

  modport master (output adr, cs, wr, rd, d_in);
  modport slave  (input  adr, cs, wr, rd, d_in);

endinterface

// File: rtl/pwm_cfg_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted channel and wraps, so the most recently served channel goes last.
module rr_arbiter #(
  parameter int NCH = 6
) (
  input  logic [NCH-1:0] req,
  input  logic [3:0]     last,
  output logic [NCH-1:0] gnt,
  output logic [3:0]     idx
);

  logic found;

  // Two passes: channels above the pointer first, then wrap to the low ones.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = 4'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Request-driven PWM configuration master: arbitrates channel requests and
// emits a disable / period / duty / enable write burst per grant.
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int                NCH       = 6,
  parameter logic [DATA_W-1:0] BASE_ADR  = 32'd0,
  parameter logic [DATA_W-1:0] CH_STRIDE = REG_STRIDE,
  parameter logic [DATA_W-1:0] OFS_EN    = REG_OFS_EN,
  parameter logic [DATA_W-1:0] OFS_PER   = REG_OFS_PER,
  parameter logic [DATA_W-1:0] OFS_DUTY  = REG_OFS_DUTY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_enable,
  input  logic [DATA_W*NCH-1:0] req_period,
  input  logic [DATA_W*NCH-1:0] req_duty,
  pwm_cfg_sequencer_if.master   bus,
  output logic                  busy,
  output logic [3:0]            grant_ch
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] d_in_q, d_in_d;
  logic [DATA_W-1:0] blk_q, blk_d;
  logic [DATA_W-1:0] per_q, per_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              en_q, en_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic [3:0]        grant_q, grant_d;
  logic [3:0]        ptr_q, ptr_d;

  logic [NCH-1:0]    arb_gnt;
  logic [3:0]        arb_idx;
  logic [DATA_W-1:0] sel_per, sel_duty;
  logic              sel_en;
  logic              accept;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req  (req_valid),
    .last (ptr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // Ready is withheld during reset so nothing is accepted while rst_n is low.
  assign req_ready = (rst_n && (state_q == IDLE)) ? arb_gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel_per  = '0;
    sel_duty = '0;
    sel_en   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_gnt[i]) begin
        sel_per  = req_period[DATA_W*i +: DATA_W];
        sel_duty = req_duty[DATA_W*i +: DATA_W];
        sel_en   = req_enable[i];
      end
    end
  end

  // Bus outputs are registered, so each state computes the next cycle's write.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    d_in_d  = d_in_q;
    blk_d   = blk_q;
    per_d   = per_q;
    duty_d  = duty_q;
    en_d    = en_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        busy_d = 1'b0;
        if (accept) begin
          blk_d   = BASE_ADR + {28'b0, arb_idx} * CH_STRIDE;
          per_d   = sel_per;
          duty_d  = sel_duty;
          en_d    = sel_en;
          grant_d = arb_idx;
          ptr_d   = arb_idx;
          state_d = W_DIS;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          adr_d   = blk_d + OFS_EN;
          d_in_d  = '0;
        end
      end
      W_DIS: begin
        state_d = W_PER;
        adr_d   = blk_q + OFS_PER;
        d_in_d  = per_q;
      end
      W_PER: begin
        state_d = W_DUTY;
        adr_d   = blk_q + OFS_DUTY;
        d_in_d  = (duty_q < per_q) ? duty_q : per_q;
      end
      W_DUTY: begin
        state_d = W_EN;
        adr_d   = blk_q + OFS_EN;
        d_in_d  = {31'b0, (en_q && (per_q != '0))};
      end
      W_EN: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      d_in_q  <= '0;
      blk_q   <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      en_q    <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= 4'(NCH - 1);
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      d_in_q  <= d_in_d;
      blk_q   <= blk_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      en_q    <= en_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.adr  = adr_q;
  assign bus.cs   = cs_q;
  assign bus.wr   = wr_q;
  assign bus.rd   = 1'b0;
  assign bus.d_in = d_in_q;
  assign busy     = busy_q;
  assign grant_ch = grant_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: reset, single bursts, clamping,
// round-robin rotation and reset in the middle of a burst.
module tb_pwm_cfg_sequencer;

  localparam int NCH = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    req_enable;
  logic [32*NCH-1:0] req_period;
  logic [32*NCH-1:0] req_duty;
  logic [31:0]       per_arr  [NCH];
  logic [31:0]       duty_arr [NCH];
  logic              busy;
  logic [3:0]        grant_ch;

  int checks = 0;
  int errors = 0;

  pwm_cfg_sequencer_if bus ();

  pwm_cfg_sequencer #(.NCH(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_enable (req_enable),
    .req_period (req_period),
    .req_duty   (req_duty),
    .bus        (bus),
    .busy       (busy),
    .grant_ch   (grant_ch)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_period = '0;
    req_duty   = '0;
    for (int i = 0; i < NCH; i++) begin
      req_period[32*i +: 32] = per_arr[i];
      req_duty[32*i +: 32]   = duty_arr[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic en, input logic [31:0] per, input logic [31:0] duty);
    for (int i = 0; i < NCH; i++) begin
      if (i == ch) begin
        req_enable[i] = en;
        per_arr[i]    = per;
        duty_arr[i]   = duty;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 6'b000001;
    set_ch(0, 1'b1, 32'd5, 32'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.cs, bus.wr, bus.rd, busy} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_ctrl: cs/wr/rd/busy got %b expected 0000", {bus.cs, bus.wr, bus.rd, busy});
      end
      checks++;
      if (bus.adr !== 32'd0 || bus.d_in !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_bus: adr %0h d_in %0h expected 0 0", bus.adr, bus.d_in);
      end
      checks++;
      if (grant_ch !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_grant: got %0d expected 0", grant_ch);
      end
      checks++;
      if (req_ready !== 6'b000000) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b expected 000000", req_ready);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL post_reset_ready: got %b expected 000001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single_writes();
    logic [31:0] blk;
    logic [31:0] exp_adr [4];
    logic [31:0] exp_dat [4];
    for (int r = 0; r < 2; r++) begin
      blk = 32'(12 * r);
      exp_adr[0] = blk;        exp_dat[0] = 32'd0;
      exp_adr[1] = blk + 32'd4; exp_dat[1] = 32'd2000000;
      exp_adr[2] = blk + 32'd8; exp_dat[2] = 32'd230000;
      exp_adr[3] = blk;        exp_dat[3] = 32'd1;
      set_ch(r, 1'b1, 32'd2000000, 32'd230000);
      req_valid = NCH'(1) << r;
      #1;
      checks++;
      if (req_ready !== (NCH'(1) << r)) begin
        errors++;
        $display("[TB] FAIL single_ready ch%0d: got %b expected %b", r, req_ready, NCH'(1) << r);
      end
      tick();
      req_valid = '0;
      checks++;
      if (grant_ch !== 4'(r)) begin
        errors++;
        $display("[TB] FAIL single_grant: got %0d expected %0d", grant_ch, r);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({bus.cs, bus.wr, busy} !== 3'b111) begin
          errors++;
          $display("[TB] FAIL single_strobe ch%0d w%0d: cs/wr/busy got %b expected 111", r, k, {bus.cs, bus.wr, busy});
        end
        checks++;
        if (bus.adr !== exp_adr[k] || bus.d_in !== exp_dat[k]) begin
          errors++;
          $display("[TB] FAIL single_write ch%0d w%0d: adr %0d d_in %0d expected %0d %0d", r, k, bus.adr, bus.d_in, exp_adr[k], exp_dat[k]);
        end
        tick();
      end
      checks++;
      if ({bus.cs, bus.wr, busy} !== 3'b000 || bus.adr !== blk || bus.d_in !== 32'd1) begin
        errors++;
        $display("[TB] FAIL single_end ch%0d: cs/wr/busy %b adr %0d d_in %0d expected 000 %0d 1", r, {bus.cs, bus.wr, busy}, bus.adr, bus.d_in, blk);
      end
    end
  endtask

  task automatic test_clamp();
    int          chs      [2] = '{4, 5};
    logic [31:0] pers     [2] = '{32'd1000, 32'd0};
    logic [31:0] dutys    [2] = '{32'd5000, 32'd7};
    logic [31:0] exp_duty [2] = '{32'd1000, 32'd0};
    logic [31:0] exp_en   [2] = '{32'd1, 32'd0};
    logic [31:0] blk;
    logic [31:0] exp_adr [4];
    logic [31:0] exp_dat [4];
    for (int r = 0; r < 2; r++) begin
      blk = 32'(12 * chs[r]);
      exp_adr[0] = blk;        exp_dat[0] = 32'd0;
      exp_adr[1] = blk + 32'd4; exp_dat[1] = pers[r];
      exp_adr[2] = blk + 32'd8; exp_dat[2] = exp_duty[r];
      exp_adr[3] = blk;        exp_dat[3] = exp_en[r];
      set_ch(chs[r], 1'b1, pers[r], dutys[r]);
      req_valid = NCH'(1) << chs[r];
      #1;
      tick();
      req_valid = '0;
      checks++;
      if (grant_ch !== 4'(chs[r])) begin
        errors++;
        $display("[TB] FAIL clamp_grant: got %0d expected %0d", grant_ch, chs[r]);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (bus.cs !== 1'b1 || bus.adr !== exp_adr[k] || bus.d_in !== exp_dat[k]) begin
          errors++;
          $display("[TB] FAIL clamp_write case%0d w%0d: cs %b adr %0d d_in %0d expected 1 %0d %0d", r, k, bus.cs, bus.adr, bus.d_in, exp_adr[k], exp_dat[k]);
        end
        tick();
      end
      checks++;
      if (bus.cs !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clamp_end case%0d: cs got %b expected 0", r, bus.cs);
      end
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 2, 5, 0};
    set_ch(0, 1'b1, 32'd100, 32'd50);
    set_ch(2, 1'b1, 32'd100, 32'd50);
    set_ch(5, 1'b1, 32'd100, 32'd50);
    req_valid = 6'b100101;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++;
      if (req_ready !== (NCH'(1) << order[g])) begin
        errors++;
        $display("[TB] FAIL rr_ready grant%0d: got %b expected %b", g, req_ready, NCH'(1) << order[g]);
      end
      tick();
      checks++;
      if (grant_ch !== 4'(order[g]) || bus.adr !== 32'(12 * order[g])) begin
        errors++;
        $display("[TB] FAIL rr_grant grant%0d: ch %0d adr %0d expected %0d %0d", g, grant_ch, bus.adr, order[g], 12 * order[g]);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (req_ready !== 6'b000000 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rr_busy grant%0d c%0d: ready %b busy %b expected 000000 1", g, k, req_ready, busy);
        end
        tick();
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    set_ch(3, 1'b1, 32'd300, 32'd100);
    req_valid = 6'b001000;
    #1;
    tick();
    req_valid = '0;
    checks++;
    if (grant_ch !== 4'd3 || bus.adr !== 32'd36) begin
      errors++;
      $display("[TB] FAIL mid_dis: ch %0d adr %0d expected 3 36", grant_ch, bus.adr);
    end
    tick();
    checks++;
    if (bus.adr !== 32'd40 || bus.d_in !== 32'd300) begin
      errors++;
      $display("[TB] FAIL mid_per: adr %0d d_in %0d expected 40 300", bus.adr, bus.d_in);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({bus.cs, bus.wr, busy} !== 3'b000 || bus.adr !== 32'd0 || bus.d_in !== 32'd0) begin
        errors++;
        $display("[TB] FAIL mid_abort c%0d: cs/wr/busy %b adr %0d d_in %0d expected 000 0 0", c, {bus.cs, bus.wr, busy}, bus.adr, bus.d_in);
      end
    end
    set_ch(4, 1'b1, 32'd400, 32'd200);
    req_valid = 6'b011000;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 6'b001000) begin
      errors++;
      $display("[TB] FAIL mid_ptr_ready: got %b expected 001000", req_ready);
    end
    tick();
    checks++;
    if (grant_ch !== 4'd3 || bus.adr !== 32'd36 || bus.cs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_regrant: ch %0d adr %0d cs %b expected 3 36 1", grant_ch, bus.adr, bus.cs);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (req_ready !== 6'b010000) begin
      errors++;
      $display("[TB] FAIL mid_next_ready: got %b expected 010000", req_ready);
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_enable = '0;
    for (int i = 0; i < NCH; i++) begin
      per_arr[i]  = '0;
      duty_arr[i] = '0;
    end
    test_reset();
    test_single_writes();
    test_clamp();
    test_round_robin();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
